// File: rtl/serial_frame_tx_if.sv
// Parallel word handshake between the command logic and the serial frame transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface serial_frame_tx_if #(
    parameter int DATA_BITS = 22
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Buffered serial frame transmitter: start bit, LSB-first data, long high guard interval.
// Words enter a small FIFO over valid/ready and are serialised one at a time.
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 2606,
    parameter int DATA_BITS    = 22,
    parameter int STOP_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    serial_frame_tx_if.slave                   tx,
    output logic                               serial_out,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      clk_cnt_r;
    logic [IDX_W-1:0]      bit_idx_r;
    logic [DATA_BITS-1:0]  shift_r;
    logic [DATA_BITS-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic                  ready_r;
    logic                  push_s;
    logic                  pop_s;
    logic [FCNT_W-1:0]     count_next_s;

    assign tx.tx_ready = ready_r;

    // Push/pop qualification and next occupancy; ready comes from registered state only.
    always_comb begin
        push_s       = tx.tx_valid && ready_r;
        pop_s        = (state_r == IDLE) && (fifo_count != {FCNT_W{1'b0}});
        count_next_s = fifo_count;
        if (push_s && !pop_s) begin
            count_next_s = fifo_count + FCNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = fifo_count - FCNT_W'(1);
        end else begin
            count_next_s = fifo_count;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx.tx_data;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_count <= {FCNT_W{1'b0}};
            ready_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fifo_count <= count_next_s;
            ready_r    <= (count_next_s != FIFO_FULL);
        end
    end

    // Frame sequencer; serial_out and busy are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            clk_cnt_r  <= {CNT_W{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            shift_r    <= {DATA_BITS{1'b0}};
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= {CNT_W{1'b0}};
                    bit_idx_r <= {IDX_W{1'b0}};
                    if (pop_s) begin
                        shift_r    <= mem_r[rd_ptr_r];
                        state_r    <= START;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        serial_out <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                START: begin
                    if (clk_cnt_r == CNT_LAST) begin
                        clk_cnt_r  <= {CNT_W{1'b0}};
                        bit_idx_r  <= {IDX_W{1'b0}};
                        state_r    <= DATA;
                        serial_out <= shift_r[0];
                        shift_r    <= shift_r >> 1;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_r == CNT_LAST) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        if (bit_idx_r == DATA_LAST) begin
                            bit_idx_r  <= {IDX_W{1'b0}};
                            state_r    <= STOP;
                            serial_out <= 1'b1;
                        end else begin
                            bit_idx_r  <= bit_idx_r + IDX_W'(1);
                            serial_out <= shift_r[0];
                            shift_r    <= shift_r >> 1;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_r == CNT_LAST) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        if (bit_idx_r == STOP_LAST) begin
                            bit_idx_r <= {IDX_W{1'b0}};
                            state_r   <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    clk_cnt_r  <= {CNT_W{1'b0}};
                    bit_idx_r  <= {IDX_W{1'b0}};
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: a scaled 22-bit instance with a receiver model,
// plus a 4-bit short-parameter instance checked cycle by cycle.
module tb_serial_frame_tx;
    localparam int CPB   = 4;
    localparam int DB    = 22;
    localparam int SB    = 8;
    localparam int FRAME = (1 + DB + SB) * CPB;

    logic       clock;
    logic       reset;
    logic       serial_a;
    logic       busy_a;
    logic [2:0] count_a;
    logic       serial_b;
    logic       busy_b;
    logic [2:0] count_b;

    int n_cmp;
    int n_err;

    logic [21:0] rx_q[$];
    int          rx_stop_err;

    serial_frame_tx_if #(.DATA_BITS(22)) if_a ();
    serial_frame_tx_if #(.DATA_BITS(4))  if_b ();

    serial_frame_tx #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(4)
    ) dut_a (
        .clock(clock), .reset(reset), .tx(if_a),
        .serial_out(serial_a), .busy(busy_a), .fifo_count(count_a)
    );

    serial_frame_tx #(
        .CLKS_PER_BIT(2), .DATA_BITS(4), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clock(clock), .reset(reset), .tx(if_b),
        .serial_out(serial_b), .busy(busy_b), .fifo_count(count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Receiver model: detect start, sample mid-bit on falling edges, verify the stop level.
    initial begin : rx_model
        logic [21:0] w;
        rx_stop_err = 0;
        w = 22'h0;
        forever begin
            @(negedge clock);
            if (serial_a === 1'b0) begin
                repeat (CPB / 2) @(negedge clock);
                for (int k = 0; k < DB; k++) begin
                    repeat (CPB) @(negedge clock);
                    w[k] = serial_a;
                end
                repeat (CPB) @(negedge clock);
                if (serial_a !== 1'b1) rx_stop_err++;
                rx_q.push_back(w);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (serial_a !== 1'b1) begin n_err++; $display("FAIL rst_serial: got %b want 1", serial_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count_a); end
        n_cmp++; if (if_a.tx_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", if_a.tx_ready); end
        n_cmp++; if (serial_b !== 1'b1) begin n_err++; $display("FAIL rst_serial_b: got %b want 1", serial_b); end
        reset = 1'b0;
        step();
        n_cmp++; if (if_a.tx_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", if_a.tx_ready); end
        n_cmp++; if (if_b.tx_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready_b: got %b want 1", if_b.tx_ready); end
        n_cmp++; if (serial_a !== 1'b1) begin n_err++; $display("FAIL rel_serial: got %b want 1", serial_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rel_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_single_word();
        logic [21:0] w;
        logic        exp_s;
        logic        exp_b;
        w = 22'h2AAAAA;
        if_a.tx_data  = w;
        if_a.tx_valid = 1'b1;
        step();
        if_a.tx_valid = 1'b0;
        n_cmp++; if (count_a !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL single_busy_pre: got %b want 0", busy_a); end
        // j counts cycles after the pop edge; the frame occupies j = 0 .. FRAME-1.
        for (int j = 0; j <= FRAME; j++) begin
            step();
            if (j < CPB) exp_s = 1'b0;
            else if (j < (1 + DB) * CPB) exp_s = w[j / CPB - 1];
            else exp_s = 1'b1;
            exp_b = (j < FRAME);
            n_cmp++; if (serial_a !== exp_s) begin n_err++; $display("FAIL single_serial j=%0d: got %b want %b", j, serial_a, exp_s); end
            n_cmp++; if (busy_a !== exp_b) begin n_err++; $display("FAIL single_busy j=%0d: got %b want %b", j, busy_a, exp_b); end
        end
    endtask

    task automatic test_loopback();
        logic [21:0] words [3];
        int idle_cycles;
        int run;
        int gap;
        words = '{22'h3FFFFF, 22'h000001, 22'h155555};
        rx_q.delete();
        idle_cycles = 0;
        run = 0;
        gap = 0;
        for (int i = 0; i < 3; i++) begin
            if_a.tx_data  = words[i];
            if_a.tx_valid = 1'b1;
            step();
        end
        if_a.tx_valid = 1'b0;
        for (int j = 2; j < 3 * (FRAME + 1) - 1; j++) begin
            step();
            if (busy_a === 1'b0) idle_cycles++;
            if (j == 2 * (FRAME + 1)) gap = run;
            if (serial_a === 1'b1) run++;
            else run = 0;
        end
        step();
        n_cmp++; if (idle_cycles !== 2) begin n_err++; $display("FAIL b2b_idle: got %0d want 2", idle_cycles); end
        n_cmp++; if (gap !== SB * CPB + 1) begin n_err++; $display("FAIL b2b_gap: got %0d want %0d", gap, SB * CPB + 1); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy: got %b want 0", busy_a); end
        repeat (4) step();
        n_cmp++; if (rx_q.size() !== 3) begin n_err++; $display("FAIL loop_size: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) begin
                n_cmp++; if (rx_q[i] !== words[i]) begin n_err++; $display("FAIL loop_word%0d: got %h want %h", i, rx_q[i], words[i]); end
            end
        end
        n_cmp++; if (rx_stop_err !== 0) begin n_err++; $display("FAIL loop_stop: got %0d want 0", rx_stop_err); end
    endtask

    task automatic test_fifo_full();
        logic [21:0] words [6];
        logic        rdy;
        logic        exp_r;
        logic        saw_full;
        int i;
        int cyc;
        words = '{22'h0ABCDE, 22'h123456, 22'h3C0FF0, 22'h00FF00, 22'h2DEAD1, 22'h1BEEF2};
        rx_q.delete();
        i = 0;
        cyc = 0;
        saw_full = 1'b0;
        while (i < 6 && cyc < 400) begin
            if_a.tx_data  = words[i];
            if_a.tx_valid = 1'b1;
            rdy = if_a.tx_ready;
            step();
            cyc++;
            if (rdy) i++;
            exp_r = (count_a != 3'd4);
            if (count_a == 3'd4) saw_full = 1'b1;
            n_cmp++; if (if_a.tx_ready !== exp_r) begin n_err++; $display("FAIL full_ready cyc=%0d count=%0d: got %b want %b", cyc, count_a, if_a.tx_ready, exp_r); end
        end
        if_a.tx_valid = 1'b0;
        n_cmp++; if (i !== 6) begin n_err++; $display("FAIL full_accept: got %0d want 6 (timeout)", i); end
        n_cmp++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL full_reached: got %b want 1", saw_full); end
        repeat (6 * (FRAME + 1) + 20) step();
        n_cmp++; if (rx_q.size() !== 6) begin n_err++; $display("FAIL full_size: got %0d want 6", rx_q.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < rx_q.size()) begin
                n_cmp++; if (rx_q[k] !== words[k]) begin n_err++; $display("FAIL full_word%0d: got %h want %h", k, rx_q[k], words[k]); end
            end
        end
    endtask

    task automatic test_push_pop();
        rx_q.delete();
        if_a.tx_data  = 22'h0F0F0F;
        if_a.tx_valid = 1'b1;
        step();
        n_cmp++; if (count_a !== 3'd1) begin n_err++; $display("FAIL pp_count_pre: got %0d want 1", count_a); end
        if_a.tx_data = 22'h30C30C;
        step();
        if_a.tx_valid = 1'b0;
        n_cmp++; if (count_a !== 3'd1) begin n_err++; $display("FAIL pp_count: got %0d want 1", count_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL pp_busy: got %b want 1", busy_a); end
        repeat (2 * (FRAME + 1) + 20) step();
        n_cmp++; if (rx_q.size() !== 2) begin n_err++; $display("FAIL pp_size: got %0d want 2", rx_q.size()); end
        if (rx_q.size() >= 2) begin
            n_cmp++; if (rx_q[0] !== 22'h0F0F0F) begin n_err++; $display("FAIL pp_word0: got %h want 0f0f0f", rx_q[0]); end
            n_cmp++; if (rx_q[1] !== 22'h30C30C) begin n_err++; $display("FAIL pp_word1: got %h want 30c30c", rx_q[1]); end
        end
        n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("FAIL pp_count_end: got %0d want 0", count_a); end
    endtask

    task automatic test_reset_mid_frame();
        int high_err;
        high_err = 0;
        if_a.tx_data  = 22'h2F0F3C;
        if_a.tx_valid = 1'b1;
        step();
        if_a.tx_data = 22'h111111;
        step();
        if_a.tx_valid = 1'b0;
        repeat (25) step();
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL mid_busy_pre: got %b want 1", busy_a); end
        n_cmp++; if (count_a !== 3'd1) begin n_err++; $display("FAIL mid_count_pre: got %0d want 1", count_a); end
        reset = 1'b1;
        step();
        n_cmp++; if (serial_a !== 1'b1) begin n_err++; $display("FAIL mid_serial: got %b want 1", serial_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy_a); end
        n_cmp++; if (count_a !== 3'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", count_a); end
        n_cmp++; if (if_a.tx_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", if_a.tx_ready); end
        reset = 1'b0;
        step();
        n_cmp++; if (if_a.tx_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_rel: got %b want 1", if_a.tx_ready); end
        for (int j = 0; j < 2 * FRAME; j++) begin
            step();
            if (serial_a !== 1'b1 || busy_a !== 1'b0) high_err++;
        end
        n_cmp++; if (high_err !== 0) begin n_err++; $display("FAIL mid_line_high: got %0d bad cycles want 0", high_err); end
    endtask

    task automatic test_short_params();
        logic [11:0] exp_wave;
        logic        exp_s;
        logic        exp_b;
        exp_wave = 12'b1111_0000_1100;
        if_b.tx_data  = 4'b1001;
        if_b.tx_valid = 1'b1;
        step();
        if_b.tx_valid = 1'b0;
        n_cmp++; if (count_b !== 3'd1) begin n_err++; $display("FAIL short_count: got %0d want 1", count_b); end
        for (int j = 0; j <= 12; j++) begin
            step();
            exp_s = (j < 12) ? exp_wave[j] : 1'b1;
            exp_b = (j < 12);
            n_cmp++; if (serial_b !== exp_s) begin n_err++; $display("FAIL short_serial j=%0d: got %b want %b", j, serial_b, exp_s); end
            n_cmp++; if (busy_b !== exp_b) begin n_err++; $display("FAIL short_busy j=%0d: got %b want %b", j, busy_b, exp_b); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        if_a.tx_data  = 22'h0;
        if_a.tx_valid = 1'b0;
        if_b.tx_data  = 4'h0;
        if_b.tx_valid = 1'b0;
        test_reset();
        test_single_word();
        test_loopback();
        test_fifo_full();
        test_push_pop();
        test_reset_mid_frame();
        test_short_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
